// File: rtl/npc_bpred_pkg.sv
// Shared types for the next-PC generator: 2-bit branch history counter
// encodings and the saturating counter update helpers.
package npc_bpred_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_SNT = 2'b00;
    localparam bht_ctr_t BHT_WNT = 2'b01;
    localparam bht_ctr_t BHT_WT  = 2'b10;
    localparam bht_ctr_t BHT_ST  = 2'b11;

    function automatic bht_ctr_t ctr_inc(input bht_ctr_t c);
        return (c == BHT_ST) ? c : c + 2'b01;
    endfunction

    function automatic bht_ctr_t ctr_dec(input bht_ctr_t c);
        return (c == BHT_SNT) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/npc_bpred_if.sv
// Fetch/EX bundle between the pipeline and the next-PC generator.
// No handshake: EX inputs are qualified by ex_valid alone, outputs are always meaningful.
interface npc_bpred_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic              ex_is_jump;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_pc;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_tgt;
    logic              flush;

    modport master (
        output stall, ex_valid, ex_is_jump, ex_taken, ex_pc, ex_target,
               ex_pred_taken, ex_pred_tgt,
        input  pc, npc, pred_taken, pred_target, flush
    );

    modport slave (
        input  stall, ex_valid, ex_is_jump, ex_taken, ex_pc, ex_target,
               ex_pred_taken, ex_pred_tgt,
        output pc, npc, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/npc_bpred_btb.sv
// Direct-mapped BTB + BHT storage: two async read ports (fetch lookup, EX training)
// and one sync write port. A write never affects reads in the same cycle.
module npc_bpred_btb
    import npc_bpred_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [ADDR_W-1:0] rd_tgt_o,
    output logic              rd_jump_o,
    output bht_ctr_t          rd_ctr_o,
    input  logic [IDX_W-1:0]  ex_idx_i,
    output logic              ex_valid_o,
    output logic [TAG_W-1:0]  ex_tag_o,
    output bht_ctr_t          ex_ctr_o,
    input  logic              we_i,
    input  logic              wr_entry_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [ADDR_W-1:0] wr_tgt_i,
    input  logic              wr_jump_i,
    input  bht_ctr_t          wr_ctr_i
);

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic              jump_q  [ENTRIES];
    bht_ctr_t          ctr_q   [ENTRIES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_tgt_o   = tgt_q[rd_idx_i];
    assign rd_jump_o  = jump_q[rd_idx_i];
    assign rd_ctr_o   = ctr_q[rd_idx_i];
    assign ex_valid_o = valid_q[ex_idx_i];
    assign ex_tag_o   = tag_q[ex_idx_i];
    assign ex_ctr_o   = ctr_q[ex_idx_i];

    // wr_entry_i=0 is a counter-only update (not-taken on a hit).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                jump_q[i]  <= 1'b0;
                ctr_q[i]   <= BHT_WNT;
            end
        end else if (we_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_i;
            if (wr_entry_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                tag_q[wr_idx_i]   <= wr_tag_i;
                tgt_q[wr_idx_i]   <= wr_tgt_i;
                jump_q[wr_idx_i]  <= wr_jump_i;
            end
        end
    end

endmodule

// File: rtl/npc_bpred.sv
// Fetch PC register with BTB/BHT prediction, EX mispredict redirect and
// predictor training. Redirect takes effect on the following fetch.
module npc_bpred
    import npc_bpred_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic         clk,
    input logic         rstn,
    npc_bpred_if.slave  bus
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IDX_W-1:0]  lk_idx, ex_idx;
    logic [TAG_W-1:0]  lk_tag, ex_tag, rd_tag, ex_rd_tag;
    logic              rd_valid, rd_jump, ex_rd_valid;
    logic [ADDR_W-1:0] rd_tgt;
    bht_ctr_t          rd_ctr, ex_rd_ctr;
    logic              lk_hit, ex_hit, pred_taken, mis;
    logic [ADDR_W-1:0] pc_plus4, pred_target, fix;
    logic              we;
    bht_ctr_t          wr_ctr;

    assign lk_idx = pc_q[IDX_W+1:2];
    assign lk_tag = pc_q[ADDR_W-1:IDX_W+2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[ADDR_W-1:IDX_W+2];

    npc_bpred_btb #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .rd_idx_i   (lk_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_tgt_o   (rd_tgt),
        .rd_jump_o  (rd_jump),
        .rd_ctr_o   (rd_ctr),
        .ex_idx_i   (ex_idx),
        .ex_valid_o (ex_rd_valid),
        .ex_tag_o   (ex_rd_tag),
        .ex_ctr_o   (ex_rd_ctr),
        .we_i       (we),
        .wr_entry_i (bus.ex_taken),
        .wr_idx_i   (ex_idx),
        .wr_tag_i   (ex_tag),
        .wr_tgt_i   (bus.ex_target),
        .wr_jump_i  (bus.ex_is_jump),
        .wr_ctr_i   (wr_ctr)
    );

    assign lk_hit      = rd_valid && (rd_tag == lk_tag);
    assign pred_taken  = lk_hit && (rd_jump || rd_ctr[1]);
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign pred_target = pred_taken ? rd_tgt : pc_plus4;

    assign mis = bus.ex_valid &&
                 ((bus.ex_taken != bus.ex_pred_taken) ||
                  (bus.ex_taken && (bus.ex_target != bus.ex_pred_tgt)));
    assign fix = bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(4);

    // A mispredict redirect wins over a stall so the wrong path is never held.
    always_comb begin
        pc_d = pred_target;
        if (bus.stall) pc_d = pc_q;
        if (mis)       pc_d = fix;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    // Taken always (re)allocates; not-taken only weakens an entry that really hits.
    assign ex_hit = ex_rd_valid && (ex_rd_tag == ex_tag);
    assign we     = bus.ex_valid && (bus.ex_taken || ex_hit);
    assign wr_ctr = bus.ex_taken ? ctr_inc(ex_rd_ctr) : ctr_dec(ex_rd_ctr);

    assign bus.pc          = pc_q;
    assign bus.npc         = pc_d;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.flush       = mis;

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: a table-level predictor model checked every
// cycle, plus literal expectations for the reset, loop, JALR, stall, alias and wrap cases.
module tb_npc_bpred;

    localparam int AW = 32;
    localparam int N  = 16;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    npc_bpred_if #(.ADDR_W(AW)) bus();

    npc_bpred #(.ADDR_W(AW), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic          m_valid [N];
    logic [AW-1:0] m_tag   [N];
    logic [AW-1:0] m_tgt   [N];
    logic          m_jump  [N];
    int            m_ctr   [N];
    logic [AW-1:0] m_pc = '0;

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] a);
        return a / (4 * N);
    endfunction

    function automatic logic m_hit(input logic [AW-1:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic m_pred(input logic [AW-1:0] a);
        return m_hit(a) && (m_jump[idx_of(a)] || (m_ctr[idx_of(a)] >= 2));
    endfunction

    function automatic logic [AW-1:0] m_ptgt(input logic [AW-1:0] a);
        return m_pred(a) ? m_tgt[idx_of(a)] : a + 32'd4;
    endfunction

    function automatic logic m_mis();
        return bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
               (bus.ex_taken && (bus.ex_target != bus.ex_pred_tgt)));
    endfunction

    function automatic logic [AW-1:0] m_npc();
        if (m_mis()) return bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
        if (bus.stall) return m_pc;
        return m_ptgt(m_pc);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc = '0;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
                m_jump[i] = 1'b0; m_ctr[i] = 1;
            end
        end else begin
            logic [AW-1:0] nxt;
            int k;
            nxt = m_npc();
            if (bus.ex_valid) begin
                k = idx_of(bus.ex_pc);
                if (bus.ex_taken) begin
                    m_valid[k] = 1'b1;
                    m_tag[k]   = tag_of(bus.ex_pc);
                    m_tgt[k]   = bus.ex_target;
                    m_jump[k]  = bus.ex_is_jump;
                    m_ctr[k]   = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                end else if (m_hit(bus.ex_pc)) begin
                    m_ctr[k]   = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                end
            end
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pc",          bus.pc,          m_pc);
        chk("npc",         bus.npc,         m_npc());
        chk("pred_taken",  {31'b0, bus.pred_taken}, {31'b0, m_pred(m_pc)});
        chk("pred_target", bus.pred_target, m_ptgt(m_pc));
        chk("flush",       {31'b0, bus.flush}, {31'b0, m_mis()});
    end

    // ---------------- driver tasks ----------------
    task automatic clear_in();
        bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_is_jump = 1'b0;
        bus.ex_taken = 1'b0; bus.ex_pc = '0; bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0; bus.ex_pred_tgt = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic apply(input logic [AW-1:0] a, input logic tk, input logic [AW-1:0] t,
                         input logic j, input logic pt, input logic [AW-1:0] ptg);
        bus.ex_valid = 1'b1; bus.ex_pc = a; bus.ex_taken = tk; bus.ex_target = t;
        bus.ex_is_jump = j; bus.ex_pred_taken = pt; bus.ex_pred_tgt = ptg;
    endtask

    // EX carries whatever the predictor said when this PC was fetched.
    task automatic resolve(input logic [AW-1:0] a, input logic tk, input logic [AW-1:0] t,
                           input logic j);
        apply(a, tk, t, j, m_pred(a), m_ptgt(a));
    endtask

    // Force fetch to address a on the next cycle via an unpredicted far jump.
    task automatic redirect(input logic [AW-1:0] a);
        apply(32'h0000_803C, 1'b1, a, 1'b1, 1'b0, '0);
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        clear_in();
        @(negedge clk);
        #2 rstn = 1'b1;
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b0;
        clear_in();

        // 1. reset and free-running fetch
        at_neg();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pred", {31'b0, bus.pred_taken}, 32'h0);
        chk("rst_flush", {31'b0, bus.flush}, 32'h0);
        #7 rstn = 1'b1;
        at_neg(); chk("run_pc0", bus.pc, 32'h0);
        at_neg(); chk("run_pc4", bus.pc, 32'h4);
        chk("run_pred", {31'b0, bus.pred_taken}, 32'h0);
        at_neg(); chk("run_pc8", bus.pc, 32'h8);
        step();
        chk("pre_rst_pc", bus.pc, 32'hC);
        #2 rstn = 1'b0;
        #1 chk("midrst_pc", bus.pc, 32'h0);
        chk("midrst_flush", {31'b0, bus.flush}, 32'h0);
        at_neg();
        #2 rstn = 1'b1;
        step();

        // 2. loop branch 0x10 -> 0x04, taken three times
        resolve(32'h10, 1'b1, 32'h04, 1'b0);
        at_neg();
        chk("loop1_flush", {31'b0, bus.flush}, 32'h1);
        chk("loop1_npc", bus.npc, 32'h04);
        step();
        resolve(32'h10, 1'b1, 32'h04, 1'b0);
        at_neg(); chk("loop2_flush", {31'b0, bus.flush}, 32'h0);
        step();
        resolve(32'h10, 1'b1, 32'h04, 1'b0);
        at_neg(); chk("loop3_flush", {31'b0, bus.flush}, 32'h0);
        step();
        redirect(32'h10);
        at_neg();
        chk("loop_pred", {31'b0, bus.pred_taken}, 32'h1);
        chk("loop_ptgt", bus.pred_target, 32'h04);
        step();

        // 3. one taken (ctr 10) then not-taken (ctr 01)
        do_reset();
        resolve(32'h10, 1'b1, 32'h04, 1'b0);
        step();
        resolve(32'h10, 1'b0, 32'h04, 1'b0);
        at_neg();
        chk("nt_flush", {31'b0, bus.flush}, 32'h1);
        chk("nt_npc", bus.npc, 32'h14);
        step();
        redirect(32'h10);
        at_neg();
        chk("nt_pred", {31'b0, bus.pred_taken}, 32'h0);
        chk("nt_ptgt", bus.pred_target, 32'h14);
        step();

        // 4. JALR target change
        resolve(32'h20, 1'b1, 32'h100, 1'b1);
        step();
        resolve(32'h20, 1'b1, 32'h200, 1'b1);
        at_neg();
        chk("jalr_flush", {31'b0, bus.flush}, 32'h1);
        chk("jalr_npc", bus.npc, 32'h200);
        step();
        redirect(32'h20);
        at_neg(); chk("jalr_ptgt", bus.pred_target, 32'h200);
        step();

        // 5. stall hold, then stall together with a mispredict
        redirect(32'h40);
        for (int c = 0; c < 3; c++) begin
            bus.stall = 1'b1;
            at_neg(); chk("stall_pc", bus.pc, 32'h40);
            step();
        end
        bus.stall = 1'b1;
        apply(32'h60, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        at_neg();
        chk("stallmis_flush", {31'b0, bus.flush}, 32'h1);
        chk("stallmis_npc", bus.npc, 32'h64);
        step();

        // 6. aliasing 0x10 / 0x50 and same-cycle collision
        resolve(32'h10, 1'b1, 32'h04, 1'b0);
        step();
        redirect(32'h50);
        at_neg();
        chk("alias_pred", {31'b0, bus.pred_taken}, 32'h0);
        chk("alias_ptgt", bus.pred_target, 32'h54);
        step();
        redirect(32'h10);
        apply(32'h50, 1'b1, 32'h80, 1'b0, 1'b0, '0);
        at_neg();
        chk("coll_pred", {31'b0, bus.pred_taken}, 32'h1);
        chk("coll_ptgt", bus.pred_target, 32'h04);
        chk("coll_npc", bus.npc, 32'h80);
        step();
        redirect(32'h10);
        at_neg(); chk("after_coll_pred", {31'b0, bus.pred_taken}, 32'h0);
        step();
        redirect(32'h50);
        at_neg(); chk("alias_new_ptgt", bus.pred_target, 32'h80);
        step();

        // +4 wraps at the top of the address space
        redirect(32'hFFFF_FFFC);
        at_neg(); chk("wrap_npc", bus.npc, 32'h0);
        step();
        at_neg(); chk("wrap_pc", bus.pc, 32'h0);
        step();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
